// File: rtl/word_shift_add_mul.sv
// Multi-cycle 16x16 unsigned shift-and-add multiplier built around a 16-bit word CLA.
// Optional zero-operand early termination: define MUL_EARLY_TERM_EN.
module word_shift_add_mul #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 ready,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product,
   output logic                 ovf
);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [2*WIDTH-1:0]   p_q, p_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   product_q, product_d;
   logic                 ovf_q, ovf_d;
   logic                 done_q, done_d;

   // Word CLA: four 4-bit groups with a second lookahead level across groups.
   logic [15:0] cla_x, cla_y, cla_g, cla_p, cla_c, cla_sum;
   logic [3:0]  grp_g, grp_p;
   logic [4:0]  grp_c;
   logic        cla_cin, cla_cout;

   assign cla_x   = p_q[2*WIDTH-1:WIDTH];
   assign cla_y   = a_q;
   assign cla_cin = 1'b0;

   always_comb begin
      cla_g = cla_x & cla_y;
      cla_p = cla_x ^ cla_y;
      for (int k = 0; k < 4; k++) begin
         grp_g[k] = cla_g[4*k+3]
                  | (cla_p[4*k+3] & cla_g[4*k+2])
                  | (cla_p[4*k+3] & cla_p[4*k+2] & cla_g[4*k+1])
                  | (cla_p[4*k+3] & cla_p[4*k+2] & cla_p[4*k+1] & cla_g[4*k]);
         grp_p[k] = &cla_p[4*k +: 4];
      end
      grp_c[0] = cla_cin;
      grp_c[1] = grp_g[0] | (grp_p[0] & cla_cin);
      grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cla_cin);
      grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
               | (grp_p[2] & grp_p[1] & grp_p[0] & cla_cin);
      grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
               | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
               | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cla_cin);
      for (int k = 0; k < 4; k++) begin
         cla_c[4*k]   = grp_c[k];
         cla_c[4*k+1] = cla_g[4*k] | (cla_p[4*k] & grp_c[k]);
         cla_c[4*k+2] = cla_g[4*k+1] | (cla_p[4*k+1] & cla_g[4*k])
                      | (cla_p[4*k+1] & cla_p[4*k] & grp_c[k]);
         cla_c[4*k+3] = cla_g[4*k+2] | (cla_p[4*k+2] & cla_g[4*k+1])
                      | (cla_p[4*k+2] & cla_p[4*k+1] & cla_g[4*k])
                      | (cla_p[4*k+2] & cla_p[4*k+1] & cla_p[4*k] & grp_c[k]);
      end
      cla_sum  = cla_p ^ cla_c;
      cla_cout = grp_c[4];
   end

   // One shift-and-add step: the CLA carry-out becomes the new accumulator MSB.
   logic [2*WIDTH-1:0] p_iter;
   assign p_iter = p_q[0] ? {cla_cout, cla_sum, p_q[WIDTH-1:1]}
                          : {1'b0, p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1:1]};

   logic early_term;
`ifdef MUL_EARLY_TERM_EN
   assign early_term = (a == '0) || (b == '0);
`else
   assign early_term = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      p_d       = p_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (early_term) begin
                  product_d = '0;
                  ovf_d     = 1'b0;
                  done_d    = 1'b1;
                  state_d   = StDone;
               end else begin
                  a_d     = a;
                  p_d     = {{WIDTH{1'b0}}, b};
                  cnt_d   = '0;
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            p_d   = p_iter;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               product_d = p_iter;
               ovf_d     = |p_iter[2*WIDTH-1:WIDTH];
               done_d    = 1'b1;
               state_d   = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         a_q       <= '0;
         p_q       <= '0;
         cnt_q     <= '0;
         product_q <= '0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         p_q       <= p_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
      end
   end

   assign ready   = (state_q == StIdle);
   assign done    = done_q;
   assign product = product_q;
   assign ovf     = ovf_q;

endmodule

// File: tb/tb_word_shift_add_mul.sv
// Directed self-checking bench for word_shift_add_mul; honours MUL_EARLY_TERM_EN.
module tb_word_shift_add_mul;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        ready;
   logic        done;
   logic [31:0] product;
   logic        ovf;

   int n_chk = 0;
   int n_bad = 0;

   word_shift_add_mul #(
      .WIDTH (16),
      .CNT_W (5)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .ready   (ready),
      .done    (done),
      .product (product),
      .ovf     (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Accept at E0 counts as latency 1; returns once done has fallen again.
   task automatic run_mul(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic [31:0] exp_p, input logic exp_ovf, input int exp_lat);
      int lat;
      @(negedge clk);
      a = ta;
      b = tb_v;
      start = 1'b1;
      @(posedge clk);
      lat = 1;
      #1;
      start = 1'b0;
      a = 16'hdead;
      b = 16'hbeef;
      check_val({tag, ".busy"}, 32'(ready), 32'd0);
      while (!done && lat < 40) begin
         @(posedge clk);
         lat++;
         #1;
      end
      check_val({tag, ".done"}, 32'(done), 32'd1);
      check_val({tag, ".lat"}, 32'(lat), 32'(exp_lat));
      check_val({tag, ".prod"}, product, exp_p);
      check_val({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
      @(posedge clk);
      #1;
      check_val({tag, ".pulse"}, 32'(done), 32'd0);
      check_val({tag, ".rdy"}, 32'(ready), 32'd1);
   endtask

   task automatic count_done(input int cycles, output int pulses);
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
   endtask

   int zero_lat;
   int pulses;
   int lat4;

   initial begin
`ifdef MUL_EARLY_TERM_EN
      zero_lat = 1;
`else
      zero_lat = 17;
`endif
      rst_n = 1'b0;
      start = 1'b0;
      a = '0;
      b = '0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst.rdy", 32'(ready), 32'd1);
      check_val("rst.done", 32'(done), 32'd0);
      check_val("rst.prod", product, 32'd0);
      check_val("rst.ovf", 32'(ovf), 32'd0);
      rst_n = 1'b1;

      run_mul("t1", 16'd3, 16'd5, 32'h0000_000F, 1'b0, 17);
      run_mul("t2", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b1, 17);
      run_mul("t3a", 16'h8000, 16'h0002, 32'h0001_0000, 1'b1, 17);
      run_mul("t3b", 16'h1234, 16'h0001, 32'h0000_1234, 1'b0, 17);
      run_mul("tx", 16'hABCD, 16'h1234, 32'h0C37_4FA4, 1'b1, 17);

      // Start pulses during RUN must be ignored and not queued.
      @(negedge clk);
      a = 16'd7;
      b = 16'd9;
      start = 1'b1;
      @(posedge clk);
      lat4 = 1;
      #1;
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         a = 16'd1;
         b = 16'd1;
         start = 1'b1;
         @(posedge clk);
         lat4++;
         #1;
         start = 1'b0;
      end
      check_val("t4.hold", product, 32'h0C37_4FA4);
      check_val("t4.holdovf", 32'(ovf), 32'd1);
      while (!done && lat4 < 40) begin
         @(posedge clk);
         lat4++;
         #1;
      end
      check_val("t4.lat", 32'(lat4), 32'd17);
      check_val("t4.prod", product, 32'h0000_003F);
      check_val("t4.ovf", 32'(ovf), 32'd0);
      count_done(24, pulses);
      check_val("t4.extra", 32'(pulses), 32'd0);

      // Reset in the middle of RUN abandons the operation.
      @(negedge clk);
      a = 16'h0055;
      b = 16'h0033;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_val("t5.rdy", 32'(ready), 32'd1);
      check_val("t5.done", 32'(done), 32'd0);
      check_val("t5.prod", product, 32'd0);
      check_val("t5.ovf", 32'(ovf), 32'd0);
      count_done(24, pulses);
      check_val("t5.nodone", 32'(pulses), 32'd0);
      run_mul("t5b", 16'd2, 16'd2, 32'h0000_0004, 1'b0, 17);

      run_mul("t6", 16'h1234, 16'h0000, 32'h0000_0000, 1'b0, zero_lat);
      run_mul("t6b", 16'h00FF, 16'h0100, 32'h0000_FF00, 1'b0, 17);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
